// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the instruction ROM, holds each word for the decoder
// over a valid/ready handshake, and handles redirects, HALT opcodes and PC range.
module instr_fetch #(
    parameter int unsigned       ADDR_W    = 20,
    parameter int unsigned       DATA_W    = 20,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       LAST_ADDR = 6,
    parameter logic [3:0]        HALT_OP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_en,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halt_pending_q, halt_pending_d;
    logic              halted_q, halted_d;
    logic              pc_in_range;
    logic              rom_en;

    // ROM enables depend only on registered state, never on same-cycle inputs.
    assign pc_in_range = (pc_q <= LastAddr);
    assign rom_en      = (state_q == StFetch) && pc_in_range;

    assign rom_address = pc_q;
    assign rom_read_en = rom_en;
    assign rom_ce      = rom_en;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        instr_valid_d  = instr_valid_q;
        halt_pending_d = halt_pending_q;
        halted_d       = halted_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Redirect wins over a coincident capture; the ROM word is dropped.
                if (redirect) begin
                    pc_d           = redirect_pc;
                    instr_valid_d  = 1'b0;
                    halt_pending_d = 1'b0;
                    state_d        = StFetch;
                end else if (pc_in_range) begin
                    instr_d        = rom_data;
                    instr_pc_d     = pc_q;
                    instr_valid_d  = 1'b1;
                    pc_d           = pc_q + ADDR_W'(1);
                    halt_pending_d = (rom_data[DATA_W-1 -: 4] == HALT_OP);
                    state_d        = StHold;
                end else begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d           = redirect_pc;
                    instr_valid_d  = 1'b0;
                    halt_pending_d = 1'b0;
                    state_d        = StFetch;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (halt_pending_q) begin
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                if (start) begin
                    pc_d           = RESET_PC;
                    halt_pending_d = 1'b0;
                    halted_d       = 1'b0;
                    state_d        = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            instr_valid_q  <= 1'b0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            instr_valid_q  <= instr_valid_d;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of ROM/redirect scenarios checked through a
// scoreboard of expected deliveries, plus hand-written backpressure/reset/HALT sequences.
module tb_instr_fetch;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rom_address;
    logic          rom_read_en;
    logic          rom_ce;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halted;

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_address(rom_address),
        .rom_read_en(rom_read_en),
        .rom_ce     (rom_ce),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom_mem [0:6];
    assign rom_data = (rom_address <= 20'd6) ? rom_mem[rom_address[2:0]] : 20'hAAAAA;

    int checks = 0;
    int passes = 0;
    int delivered = 0;
    logic bad_en = 1'b0;
    logic [AW-1:0] exp_pc[$];
    logic [DW-1:0] exp_instr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Scoreboard: every accepted, non-squashed word must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_ce && rom_address > 20'd6) bad_en = 1'b1;
            if (rom_ce !== rom_read_en) bad_en = 1'b1;
            if (instr_valid && instr_ready && !redirect) begin
                delivered++;
                if (exp_pc.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got pc %0h instr %0h, required none",
                             instr_pc, instr);
                end else begin
                    check("word_pc", 32'(instr_pc), 32'(exp_pc.pop_front()));
                    check("word_instr", 32'(instr), 32'(exp_instr.pop_front()));
                end
            end
        end
    end

    typedef struct {
        int halt_word;   // index holding HALT_OP, 7 for none
        int redir_at;    // held pc at which redirect is asserted, -1 for none
        int redir_pc;
        int exp_count;
    } case_t;

    case_t cases [5];

    task automatic fill_rom(input int halt_word);
        for (int i = 0; i < 7; i++) rom_mem[i] = (i == halt_word) ? 20'hF0000 : 20'(i + 1);
    endtask

    // Reference walk of the ROM producing the expected delivery order.
    task automatic build_expect(input int halt_word, input int redir_at, input int redir_pc);
        int pc = 0;
        int used = 0;
        while (pc <= 6) begin
            if (pc == redir_at && used == 0) begin
                used = 1;
                pc = redir_pc;
                continue;
            end
            exp_pc.push_back(20'(pc));
            exp_instr.push_back(rom_mem[pc]);
            if (pc == halt_word) break;
            pc++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_pc.delete();
        exp_instr.delete();
        delivered = 0;
        bad_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_until_halt(input int budget, input int redir_at, input int redir_pc);
        logic done = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < budget && !halted; i++) begin
            @(posedge clk);
            #1;
            if (!done && instr_valid && instr_pc == 20'(redir_at)) begin
                redirect    = 1'b1;
                redirect_pc = 20'(redir_pc);
                done        = 1'b1;
            end else begin
                redirect = 1'b0;
            end
        end
        redirect = 1'b0;
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        cases[0] = '{halt_word: 7, redir_at: -1, redir_pc: 0, exp_count: 7};
        cases[1] = '{halt_word: 3, redir_at: -1, redir_pc: 0, exp_count: 4};
        cases[2] = '{halt_word: 7, redir_at: 1,  redir_pc: 5, exp_count: 3};
        cases[3] = '{halt_word: 7, redir_at: 2,  redir_pc: 9, exp_count: 2};
        cases[4] = '{halt_word: 0, redir_at: -1, redir_pc: 0, exp_count: 1};

        rst_n = 1'b0;
        start = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        fill_rom(7);
        #12 rst_n = 1'b1;

        // Reset state and no fetch without start, even with redirect asserted.
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", 32'(rom_address), 32'd0);
        redirect = 1'b1;
        redirect_pc = 20'd4;
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 redirect = 1'b0;
        check("idle_ce", 32'(rom_ce), 32'd0);
        check("idle_addr", 32'(rom_address), 32'd0);

        for (int c = 0; c < 5; c++) begin
            fill_rom(cases[c].halt_word);
            do_reset();
            build_expect(cases[c].halt_word, cases[c].redir_at, cases[c].redir_pc);
            pulse_start();
            run_until_halt(60, cases[c].redir_at, cases[c].redir_pc);
            repeat (2) @(posedge clk);
            #1;
            check("case_queue_left", 32'(exp_pc.size()), 32'd0);
            check("case_count", 32'(delivered), 32'(cases[c].exp_count));
            check("case_rom_range", 32'(bad_en), 32'd0);
            check("case_halt_ce", 32'(rom_ce), 32'd0);
            check("case_halt_valid", 32'(instr_valid), 32'd0);
        end

        // Backpressure on word 2.
        fill_rom(7);
        do_reset();
        build_expect(7, -1, 0);
        instr_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (instr_valid && instr_pc == 20'd2) break;
            @(posedge clk);
            #1;
        end
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_instr", 32'(instr), 32'h00003);
            check("bp_pc", 32'(instr_pc), 32'd2);
            check("bp_ce", 32'(rom_ce), 32'd0);
        end
        run_until_halt(60, -1, 0);
        #1;
        check("bp_queue_left", 32'(exp_pc.size()), 32'd0);
        check("bp_count", 32'(delivered), 32'd7);

        // Asynchronous reset while holding word 0.
        do_reset();
        instr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10 && !instr_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_instr", 32'(instr), 32'd0);
        check("async_halted", 32'(halted), 32'd0);
        #2 rst_n = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_ce", 32'(rom_ce), 32'd0);
            check("post_rst_valid", 32'(instr_valid), 32'd0);
        end
        delivered = 0;
        build_expect(7, -1, 0);
        pulse_start();
        run_until_halt(60, -1, 0);
        #1;
        check("restart_queue_left", 32'(exp_pc.size()), 32'd0);

        // Redirect ignored in HALT, then restart from HALT.
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 20'd3;
        @(posedge clk);
        #1 redirect = 1'b0;
        check("halt_redir_halted", 32'(halted), 32'd1);
        check("halt_redir_ce", 32'(rom_ce), 32'd0);
        delivered = 0;
        build_expect(7, -1, 0);
        pulse_start();
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_addr", 32'(rom_address), 32'd0);
        run_until_halt(60, -1, 0);
        #1;
        check("rehalt_queue_left", 32'(exp_pc.size()), 32'd0);
        check("rehalt_count", 32'(delivered), 32'd7);
        check("rehalt_rom_range", 32'(bad_en), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
